// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing an 8-LED bank among NUM_REQ pattern sources, with a
// minimum time slice in prescaled ticks. Optional brightness PWM: define LED_ARB_PWM_EN.
module led_bank_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         PRESCALE     = 12000,
  parameter int         SLICE_TICKS  = 250,
  parameter logic [7:0] IDLE_PATTERN = 8'h00
) (
  input  logic                   CLK_IN,
  input  logic                   RSTN_IN,
  input  logic [NUM_REQ-1:0]     REQ_IN,
  input  logic [8*NUM_REQ-1:0]   PATTERN_IN,
  input  logic [3:0]             DUTY_IN,
  output logic [NUM_REQ-1:0]     GRANT_OUT,
  output logic [7:0]             LED_OUT,
  output logic                   TICK_OUT
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(SLICE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLICE_LOAD = SW'(SLICE_TICKS);
  localparam logic [SW-1:0] SLICE_ONE  = SW'(1'b1);
  localparam logic [SW-1:0] SLICE_ZERO = {SW{1'b0}};
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   CNT_W      = (IW + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OWN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [SW-1:0]       slice_q, slice_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [7:0]          led_q, led_d;

  logic [NUM_REQ-1:0]  req_mask_s;
  logic [IW:0]         cand_s;
  logic                win_found_s;
  logic [IW-1:0]       win_idx_s;
  logic [IW-1:0]       rr_next_s;
  logic                expire_s;
  logic                take_s;
  logic [SW-1:0]       slice_keep_s;
  logic [7:0]          led_pat_s;

  // Free-running prescaler; the tick register is high exactly while the count sits at its last value.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? {PW{1'b0}} : presc_q + PW'(1'b1);
    tick_d  = (presc_d == PRESC_LAST);
  end

  // Current owner is masked out, so in OWN this finds "the others" and in IDLE everyone.
  always_comb begin
    req_mask_s  = REQ_IN & ~grant_q;
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    cand_s      = {(IW + 1){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s      = {1'b0, rr_q} + (IW + 1)'(i);
      cand_s      = (cand_s >= CNT_W) ? (cand_s - CNT_W) : cand_s;
      win_idx_s   = (!win_found_s && req_mask_s[cand_s[IW-1:0]]) ? cand_s[IW-1:0] : win_idx_s;
      win_found_s = win_found_s | req_mask_s[cand_s[IW-1:0]];
    end
    rr_next_s = (win_idx_s == IDX_LAST) ? {IW{1'b0}} : win_idx_s + IW'(1'b1);
    expire_s  = tick_q && (slice_q == SLICE_ONE);
  end

  always_comb begin
    state_d      = state_q;
    take_s       = 1'b0;
    slice_keep_s = slice_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          take_s  = 1'b1;
          state_d = S_OWN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        if (!REQ_IN[owner_q]) begin
          if (win_found_s) begin
            take_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (expire_s) begin
          // Lone requester renews its own slice rather than passing through IDLE.
          if (win_found_s) begin
            take_s = 1'b1;
          end else begin
            slice_keep_s = SLICE_LOAD;
          end
        end else if (tick_q && (slice_q != SLICE_ZERO)) begin
          slice_keep_s = slice_q - SLICE_ONE;
        end else begin
          slice_keep_s = slice_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (take_s) begin
      grant_d = ONE_HOT0 << win_idx_s;
      owner_d = win_idx_s;
      rr_d    = rr_next_s;
      slice_d = SLICE_LOAD;
    end else if (state_d == S_OWN) begin
      grant_d = grant_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      slice_d = slice_keep_s;
    end else begin
      grant_d = {NUM_REQ{1'b0}};
      owner_d = owner_q;
      rr_d    = rr_q;
      slice_d = slice_keep_s;
    end
  end

`ifdef LED_ARB_PWM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
    if (!RSTN_IN) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end
`else
  logic unused_duty_s;
  assign unused_duty_s = ^DUTY_IN;
`endif

  // LED follows the owner that will hold the grant after this edge.
  always_comb begin
    if (state_d == S_OWN) begin
      led_pat_s = PATTERN_IN[{owner_d, 3'b000} +: 8];
    end else begin
      led_pat_s = IDLE_PATTERN;
    end
`ifdef LED_ARB_PWM_EN
    led_d = led_pat_s & {8{pwm_q < DUTY_IN}};
`else
    led_d = led_pat_s;
`endif
  end

  always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
    if (!RSTN_IN) begin
      state_q <= S_IDLE;
      grant_q <= {NUM_REQ{1'b0}};
      owner_q <= {IW{1'b0}};
      rr_q    <= {IW{1'b0}};
      slice_q <= SLICE_ZERO;
      presc_q <= {PW{1'b0}};
      tick_q  <= 1'b0;
      led_q   <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      slice_q <= slice_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
    end
  end

  assign GRANT_OUT = grant_q;
  assign LED_OUT   = led_q;
  assign TICK_OUT  = tick_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: ownership model checked every cycle plus
// directed literal expectations (NUM_REQ=4, PRESCALE=4, SLICE_TICKS=2).
module tb_led_bank_arbiter;

  localparam int N = 4;
  localparam int P = 4;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [3:0]  duty;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        tick;

  int checks = 0;
  int errors = 0;

  int         m_owner, m_rr, m_used, m_edges;
  logic       m_tick;
  logic [7:0] m_led;
  logic [3:0]  cap_req;
  logic [31:0] cap_pat;
  logic [3:0]  cap_duty;
  logic        cap_valid;
  bit          chk_en = 1'b0;

  logic [3:0] rr_seen [4];
  int         rr_dur  [4];
  logic [3:0] rr_exp  [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [3:0] vec     [5] = '{4'b0110, 4'b1111, 4'b0101, 4'b1000, 4'b0011};
  int         ng, cur_len, idle_gap, ntick, npwm;
  logic [3:0] prev_g;

  led_bank_arbiter #(
    .NUM_REQ(4), .PRESCALE(4), .SLICE_TICKS(2), .IDLE_PATTERN(8'h00)
  ) dut (
    .CLK_IN(clk), .RSTN_IN(rstn), .REQ_IN(req), .PATTERN_IN(pat), .DUTY_IN(duty),
    .GRANT_OUT(grant), .LED_OUT(led), .TICK_OUT(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int excl, input int rr);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (rr + i) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_used = 0; m_edges = 0; m_tick = 1'b0; m_led = 8'h00;
  endtask

  task automatic model_grant(input int w);
    m_owner = w; m_used = 0; m_rr = (w + 1) % N;
  endtask

  // One clock edge of the ownership rules, using inputs captured at that edge.
  task automatic model_step();
    int w;
    if (m_owner < 0) begin
      w = pick(cap_req, -1, m_rr);
      if (w >= 0) model_grant(w);
    end else if (!cap_req[m_owner]) begin
      w = pick(cap_req, m_owner, m_rr);
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else if (m_tick) begin
      m_used++;
      if (m_used == S) begin
        w = pick(cap_req, m_owner, m_rr);
        if (w >= 0) model_grant(w);
        else m_used = 0;
      end
    end
    m_led = (m_owner < 0) ? 8'h00 : cap_pat[m_owner*8 +: 8];
`ifdef LED_ARB_PWM_EN
    if ((m_edges % 16) >= int'(cap_duty)) m_led = 8'h00;
`endif
    m_edges++;
    m_tick = ((m_edges % P) == P - 1);
  endtask

  always @(posedge clk) begin
    cap_req   <= req;
    cap_pat   <= pat;
    cap_duty  <= duty;
    cap_valid <= rstn;
  end

  always @(negedge clk) begin
    if (cap_valid === 1'b1 && rstn === 1'b1) model_step();
    if (chk_en) begin
      check("cmp_grant", grant, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
      check("cmp_led", led, m_led);
      check("cmp_tick", tick, m_tick);
    end
  end

  initial begin
    rstn = 1'b0; req = 4'b0000; duty = 4'd0;
    pat  = {8'h3C, 8'h33, 8'hA5, 8'h11};
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1; chk_en = 1'b1;

    // single requester, slice renewals
    req = 4'b0010;
    @(negedge clk);
    check("single_grant", grant, 4'b0010);
    check("single_led", led, 8'hA5);
    repeat (44) @(negedge clk);
    check("single_hold", grant, 4'b0010);

    // asynchronous reset mid-grant
    #2; rstn = 1'b0; chk_en = 1'b0; #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_led", led, 8'h00);
    check("rst_tick", tick, 1'b0);
    model_reset(); req = 4'b0000;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1; chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("tick_first", tick, 1'b1);
    ntick = 0;
    repeat (16) begin
      @(negedge clk);
      ntick += int'(tick);
    end
    check("tick_count", ntick, 4);

    // round robin under contention
    req = 4'b1011; ng = 0; cur_len = 0; idle_gap = 0; prev_g = 4'b0000;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      @(negedge clk);
      if (grant == 4'b0000) begin
        if (ng > 0) idle_gap++;
      end else if (grant != prev_g) begin
        if (ng > 0) rr_dur[ng-1] = cur_len;
        rr_seen[ng] = grant;
        ng++;
        cur_len = 1;
      end else begin
        cur_len++;
      end
      prev_g = grant;
    end
    check("rr_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) check("rr_order", rr_seen[k], rr_exp[k]);
    end
    for (int k = 0; k < 3; k++) begin
      if (k + 1 < ng) check("rr_duration_5to8", (rr_dur[k] >= 5 && rr_dur[k] <= 8), 1);
    end
    check("rr_idle_gap", idle_gap, 0);

    // early release
    req = 4'b0010; @(negedge clk);
    check("er_to1", grant, 4'b0010);
    req = 4'b1001; @(negedge clk);
    check("er_to3", grant, 4'b1000);
    req = 4'b0010; @(negedge clk);
    check("er_back1", grant, 4'b0010);
    req = 4'b0000; @(negedge clk);
    check("er_idle", grant, 4'b0000);
    check("er_idle_led", led, 8'h00);

    // live pattern update
    pat[31:24] = 8'h0F; req = 4'b1000; @(negedge clk);
    check("live_grant", grant, 4'b1000);
    check("live_led0", led, 8'h0F);
    pat[31:24] = 8'hF0; @(negedge clk);
    check("live_led1", led, 8'hF0);
    check("live_hold", grant, 4'b1000);

    // request dropped in the cycle its grant is issued
    req = 4'b0000; @(negedge clk);
    req = 4'b0100;
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    check("drop_grant", grant, 4'b0100);
    @(negedge clk);
    check("drop_release", grant, 4'b0000);

    // assorted request patterns, checked by the model
    for (int v = 0; v < 5; v++) begin
      req = vec[v];
      repeat (13) @(negedge clk);
    end

`ifdef LED_ARB_PWM_EN
    pat[7:0] = 8'hFF; req = 4'b0001; duty = 4'd4;
    @(negedge clk); @(negedge clk);
    npwm = 0;
    repeat (16) begin
      @(negedge clk);
      if (led == 8'hFF) npwm++;
    end
    check("pwm_duty4", npwm, 4);
    duty = 4'd0; @(negedge clk);
    npwm = 0;
    repeat (16) begin
      @(negedge clk);
      if (led != 8'h00) npwm++;
    end
    check("pwm_duty0", npwm, 0);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
